// File: rtl/collide_event_arbiter.sv
// collide_event_arbiter
// Turns per-object collision flags into a single valid/ready event stream.
// Each 0->1 transition of a flag sets a sticky pending bit. Pending bits are
// offered to the consumer in round-robin order. The number of completed
// handshakes per video frame is capped. When the cap is reached the arbiter
// parks in HOLD until the next vsync rising edge.
module collide_event_arbiter #(
  parameter int N_REQ         = 4,
  parameter int MAX_PER_FRAME = 4,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             vsync,
  input  logic [N_REQ-1:0] req,
  input  logic             ev_ready,
  output logic             ev_valid,
  output logic [1:0]       ev_id,
  output logic [N_REQ-1:0] pending,
  output logic [7:0]       frame_grants,
  output logic [CNT_W-1:0] drop_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OFFER = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  // One extra bit catches the carry out of the saturating drop counter.
  localparam int         DW    = CNT_W + 1;
  localparam logic [7:0] MAX_C = 8'(MAX_PER_FRAME);

  state_t             state_r, state_nxt_s;
  logic               ev_valid_r, ev_valid_nxt_s;
  logic [1:0]         ev_id_r, ev_id_nxt_s;
  logic [1:0]         rr_ptr_r, rr_ptr_nxt_s;
  logic [N_REQ-1:0]   pending_r, pending_nxt_s;
  logic [7:0]         frame_grants_r, frame_grants_nxt_s;
  logic [CNT_W-1:0]   drop_cnt_r, drop_cnt_nxt_s;
  logic [N_REQ-1:0]   req_d_r;
  logic               vsync_d_r;

  logic [N_REQ-1:0]   rise_s, clr_s, drop_vec_s, pend_sh_s, drop_sh_s;
  logic               vsync_rise_s, hs_s, pick_found_s;
  logic [1:0]         pick_id_s;
  logic [DW-1:0]      drop_sum_s;
  int                 idx_s;

  assign ev_valid     = ev_valid_r;
  assign ev_id        = ev_id_r;
  assign pending      = pending_r;
  assign frame_grants = frame_grants_r;
  assign drop_cnt     = drop_cnt_r;

  // Edge detection, pending set/clear, drop counting and frame budget update.
  always_comb begin
    rise_s       = req & ~req_d_r;
    vsync_rise_s = vsync & ~vsync_d_r;
    hs_s         = (state_r == ST_OFFER) && ev_valid_r && ev_ready;
    if (hs_s) begin
      clr_s = N_REQ'(1) << ev_id_r;
    end else begin
      clr_s = '0;
    end
    // A rise on the bit being cleared this cycle is a fresh event, not a drop.
    pending_nxt_s = (pending_r & ~clr_s) | rise_s;
    drop_vec_s    = rise_s & pending_r & ~clr_s;
    drop_sum_s    = {1'b0, drop_cnt_r};
    drop_sh_s     = '0;
    for (int i = 0; i < N_REQ; i++) begin
      drop_sh_s  = drop_vec_s >> i;
      drop_sum_s = drop_sum_s + DW'(drop_sh_s[0]);
    end
    if (drop_sum_s[CNT_W]) begin
      drop_cnt_nxt_s = '1;
    end else begin
      drop_cnt_nxt_s = drop_sum_s[CNT_W-1:0];
    end
    // A new frame zeroes the count even when it coincides with a handshake.
    if (vsync_rise_s) begin
      frame_grants_nxt_s = 8'd0;
    end else if (hs_s) begin
      frame_grants_nxt_s = frame_grants_r + 8'd1;
    end else begin
      frame_grants_nxt_s = frame_grants_r;
    end
  end

  // Round-robin pick: first registered pending bit at or above rr_ptr, wrapping.
  always_comb begin
    pick_found_s = 1'b0;
    pick_id_s    = 2'd0;
    idx_s        = 0;
    pend_sh_s    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx_s     = (int'(rr_ptr_r) + k) % N_REQ;
      pend_sh_s = pending_r >> idx_s;
      if (!pick_found_s && pend_sh_s[0]) begin
        pick_found_s = 1'b1;
        pick_id_s    = 2'(idx_s);
      end else begin
        pick_found_s = pick_found_s;
      end
    end
  end

  // FSM next-state and offer/pointer logic.
  always_comb begin
    state_nxt_s    = state_r;
    ev_valid_nxt_s = ev_valid_r;
    ev_id_nxt_s    = ev_id_r;
    rr_ptr_nxt_s   = rr_ptr_r;
    case (state_r)
      ST_IDLE: begin
        if (pick_found_s && (frame_grants_r < MAX_C)) begin
          ev_valid_nxt_s = 1'b1;
          ev_id_nxt_s    = pick_id_s;
          state_nxt_s    = ST_OFFER;
        end else if ((frame_grants_r >= MAX_C) && !vsync_rise_s) begin
          // A coincident vsync rise refills the budget, so there is no need to park.
          state_nxt_s = ST_HOLD;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_OFFER: begin
        if (hs_s) begin
          ev_valid_nxt_s = 1'b0;
          if (ev_id_r == 2'(N_REQ - 1)) begin
            rr_ptr_nxt_s = 2'd0;
          end else begin
            rr_ptr_nxt_s = ev_id_r + 2'd1;
          end
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_OFFER;
        end
      end
      ST_HOLD: begin
        ev_valid_nxt_s = 1'b0;
        if (vsync_rise_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_HOLD;
        end
      end
      default: begin
        ev_valid_nxt_s = 1'b0;
        state_nxt_s    = ST_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Datapath registers: offer, pointer, pending, counters and edge-detect history.
  always_ff @(posedge clk) begin
    if (rst) begin
      ev_valid_r     <= 1'b0;
      ev_id_r        <= 2'd0;
      rr_ptr_r       <= 2'd0;
      pending_r      <= '0;
      frame_grants_r <= 8'd0;
      drop_cnt_r     <= '0;
      req_d_r        <= '0;
      vsync_d_r      <= 1'b0;
    end else begin
      ev_valid_r     <= ev_valid_nxt_s;
      ev_id_r        <= ev_id_nxt_s;
      rr_ptr_r       <= rr_ptr_nxt_s;
      pending_r      <= pending_nxt_s;
      frame_grants_r <= frame_grants_nxt_s;
      drop_cnt_r     <= drop_cnt_nxt_s;
      req_d_r        <= req;
      vsync_d_r      <= vsync;
    end
  end

endmodule

// File: tb/tb_collide_event_arbiter.sv
// Bench for collide_event_arbiter.
// A table of request patterns feeds a scoreboard of expected grant ids.
// Hand-written sequences cover budget hold, stall/drop, set-vs-clear and reset.
module tb_collide_event_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       vsync = 1'b0;
  logic [3:0] req = 4'd0;
  logic       ev_ready = 1'b0;
  logic       ev_valid;
  logic [1:0] ev_id;
  logic [3:0] pending;
  logic [7:0] frame_grants;
  logic [7:0] drop_cnt;

  int n_checks = 0;
  int n_pass   = 0;
  logic [1:0] exp_q[$];
  logic [1:0] sb_exp;

  typedef struct {
    logic [3:0] req_pat;
    int         n;
    logic [7:0] ids;   // id k lives in bits [2k+1:2k]
  } vec_t;

  vec_t vecs[7];

  collide_event_arbiter #(.N_REQ(4), .MAX_PER_FRAME(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .vsync(vsync), .req(req), .ev_ready(ev_ready),
    .ev_valid(ev_valid), .ev_id(ev_id), .pending(pending),
    .frame_grants(frame_grants), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic new_frame();
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
    tick();
  endtask

  // Scoreboard: every handshake seen must match the next expected id.
  always @(negedge clk) begin
    if (!rst && ev_valid && ev_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL sb_unexpected: got grant id %0d, expected no grant", ev_id);
      end else begin
        sb_exp = exp_q.pop_front();
        chk("sb_grant_id", int'(ev_id), int'(sb_exp));
      end
    end
  end

  initial begin
    vec_t v;
    int   viol;

    vecs[0] = '{4'b1111, 4, 8'hE4};  // 0,1,2,3
    vecs[1] = '{4'b0100, 1, 8'h02};  // 2
    vecs[2] = '{4'b0011, 2, 8'h04};  // 0,1
    vecs[3] = '{4'b1001, 2, 8'h03};  // 3,0
    vecs[4] = '{4'b1010, 2, 8'h0D};  // 1,3
    vecs[5] = '{4'b0110, 2, 8'h09};  // 1,2
    vecs[6] = '{4'b1000, 1, 8'h03};  // 3

    // Reset state
    repeat (2) tick();
    chk("rst_ev_valid", int'(ev_valid), 0);
    chk("rst_ev_id", int'(ev_id), 0);
    chk("rst_pending", int'(pending), 0);
    chk("rst_frame_grants", int'(frame_grants), 0);
    chk("rst_drop_cnt", int'(drop_cnt), 0);
    rst = 1'b0;
    ev_ready = 1'b1;
    tick();

    // Table-driven patterns with ev_ready held high
    for (int i = 0; i < 7; i++) begin
      v = vecs[i];
      new_frame();
      for (int k = 0; k < v.n; k++) exp_q.push_back(v.ids[2*k +: 2]);
      req = v.req_pat;
      tick();
      req = 4'd0;
      repeat (2 * v.n + 4) tick();
      chk("vec_pending", int'(pending), 0);
      chk("vec_frame_grants", int'(frame_grants), v.n);
      chk("vec_sb_drained", exp_q.size(), 0);
    end

    // Single pulse: offer exactly two edges after the rise, for one cycle
    new_frame();
    exp_q.push_back(2'd2);
    req = 4'b0100;
    tick();
    chk("t1_pending_set", int'(pending), 4);
    chk("t1_no_valid_yet", int'(ev_valid), 0);
    req = 4'd0;
    tick();
    chk("t1_valid", int'(ev_valid), 1);
    chk("t1_id", int'(ev_id), 2);
    tick();
    chk("t1_valid_drop", int'(ev_valid), 0);
    chk("t1_pending_clr", int'(pending), 0);
    chk("t1_frame_grants", int'(frame_grants), 1);

    // Budget cap: after 4 grants nothing is offered until vsync rises
    new_frame();
    exp_q.push_back(2'd3); exp_q.push_back(2'd0);
    exp_q.push_back(2'd1); exp_q.push_back(2'd2);
    req = 4'b1111;
    tick();
    req = 4'd0;
    repeat (12) tick();
    chk("t3_frame_grants_cap", int'(frame_grants), 4);
    req = 4'b0001;
    tick();
    req = 4'd0;
    viol = 0;
    for (int j = 0; j < 8; j++) begin
      if (ev_valid) viol++;
      tick();
    end
    chk("t3_hold_no_valid", viol, 0);
    chk("t3_pending_queued", int'(pending), 1);
    exp_q.push_back(2'd0);
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
    chk("t3_vsync_clears_grants", int'(frame_grants), 0);
    repeat (3) tick();
    chk("t3_after_vsync_grants", int'(frame_grants), 1);
    chk("t3_after_vsync_pending", int'(pending), 0);
    chk("t3_sb_drained", exp_q.size(), 0);

    // Stall: offer stays stable, a re-rise of the offered bit is dropped
    new_frame();
    ev_ready = 1'b0;
    req = 4'b0010;
    tick();
    req = 4'd0;
    tick();
    chk("t4_valid", int'(ev_valid), 1);
    chk("t4_id", int'(ev_id), 1);
    req = 4'b0010;
    tick();
    req = 4'd0;
    viol = 0;
    for (int j = 0; j < 9; j++) begin
      if (!ev_valid || ev_id != 2'd1) viol++;
      tick();
    end
    chk("t4_stable", viol, 0);
    chk("t4_drop_cnt", int'(drop_cnt), 1);
    chk("t4_pending_held", int'(pending), 2);
    exp_q.push_back(2'd1);
    ev_ready = 1'b1;
    tick();
    chk("t4_valid_drop", int'(ev_valid), 0);
    chk("t4_pending_clr", int'(pending), 0);

    // Rise on the bit being granted in the same cycle: re-queued, not dropped
    new_frame();
    ev_ready = 1'b0;
    req = 4'b0010;
    tick();
    req = 4'd0;
    tick();
    chk("t5_valid", int'(ev_valid), 1);
    exp_q.push_back(2'd1);
    exp_q.push_back(2'd1);
    ev_ready = 1'b1;
    req = 4'b0010;
    tick();
    chk("t5_pending_kept", int'(pending), 2);
    chk("t5_drop_unchanged", int'(drop_cnt), 1);
    chk("t5_valid_low", int'(ev_valid), 0);
    req = 4'd0;
    tick();
    chk("t5_reoffer_valid", int'(ev_valid), 1);
    chk("t5_reoffer_id", int'(ev_id), 1);
    tick();
    chk("t5_pending_clr", int'(pending), 0);
    chk("t5_sb_drained", exp_q.size(), 0);

    // Drop counter saturation while an offer is stalled
    new_frame();
    ev_ready = 1'b0;
    req = 4'b0100;
    tick();
    req = 4'd0;
    tick();
    chk("t7_valid", int'(ev_valid), 1);
    chk("t7_id", int'(ev_id), 2);
    for (int j = 0; j < 300; j++) begin
      req = 4'b0100;
      tick();
      req = 4'd0;
      tick();
    end
    chk("t7_drop_saturated", int'(drop_cnt), 255);

    // Reset during an offer, then a normal grant
    rst = 1'b1;
    tick();
    chk("t6_ev_valid", int'(ev_valid), 0);
    chk("t6_ev_id", int'(ev_id), 0);
    chk("t6_pending", int'(pending), 0);
    chk("t6_frame_grants", int'(frame_grants), 0);
    chk("t6_drop_cnt", int'(drop_cnt), 0);
    rst = 1'b0;
    ev_ready = 1'b1;
    exp_q.push_back(2'd2);
    req = 4'b0100;
    tick();
    req = 4'd0;
    repeat (4) tick();
    chk("t6_grant_pending", int'(pending), 0);
    chk("t6_grant_frame", int'(frame_grants), 1);
    chk("t6_sb_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
